forward_ctrl: RTL
=================

// Module: forward_ctrl
// PURPOSE
//  Operand-forwarding and load-use hazard controller for the 16-bit pipelined core.
//  Produces the 2-bit select codes that drive the EX-stage 16-bit 3:1 operand muxes
//  (00 = register file, 01 = EX/MEM result, 10 = MEM/WB result).
//  Tracks in-flight destination registers and stalls ID one cycle on a load-use hazard.
//  Sits between the ID decode outputs and the ID/EX pipeline register.
// PARAMETERS
//  REG_W     3    width of a register index (8 architectural registers; R0 reads as zero)
//  CNT_W     16   width of the stall performance counter
// PORTS
//  clk          in   1      single system clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  id_valid     in   1      ID holds a real instruction
//  id_rs        in   REG_W  source register A of ID instruction
//  id_rt        in   REG_W  source register B of ID instruction
//  id_use_rs    in   1      ID instruction reads rs
//  id_use_rt    in   1      ID instruction reads rt
//  id_wr_en     in   1      ID instruction writes a register
//  id_rd        in   REG_W  destination register of ID instruction
//  id_is_load   in   1      ID instruction is a memory load
//  flush        in   1      branch taken: kill the ID instruction
//  fwd_sel_a    out  2      registered mux select for EX operand A
//  fwd_sel_b    out  2      registered mux select for EX operand B
//  stall        out  1      combinational: hold PC and IF/ID, insert bubble
//  stall_count  out  CNT_W  saturating count of stall cycles
// BEHAVIOUR
//  - Internal slots EX and MEM, each {valid, wr_en, rd, is_load}; shift EX->MEM every cycle.
//  - EX slot loads from ID inputs when id_valid & ~stall & ~flush; else loads a bubble (valid=0).
//  - A slot "matches" source s when valid & wr_en & rd==s & s!=0 & use_s.
//  - Select computed in ID, registered into fwd_sel_* at the edge the instruction enters EX:
//      EX-slot match -> 01; else MEM-slot match -> 10; else 00. EX slot has priority.
//  - Code 11 is never produced.
//  - stall = id_valid & ~flush & EX.valid & EX.is_load & (EX matches rs or rt).
//  - During stall: fwd_sel_* register 00 (bubble), EX slot gets a bubble, ID inputs held by core.
//    Next cycle the load sits in MEM slot -> hazard resolves to select 10; exactly one stall cycle.
//  - flush has priority over stall: stall=0, EX slot bubble, fwd_sel_* register 00.
//  - stall_count increments each cycle stall=1; saturates at all-ones, never wraps.
//  - Reset (any time, incl. mid-stall): slots invalid, fwd_sel_a/b=00, stall=0, stall_count=0.
//    First edge after reset release behaves as a cold pipeline (no forwarding).
//  - Latency: fwd_sel_* valid one cycle after ID presentation; stall zero-cycle (combinational).
// STRUCTURE
//  - Shared include fwd_defs.vh: FWD_REGFILE=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
//  - One sub-module fwd_compare (combinational): takes one source index + use flag + EX and
//    MEM slots, returns 2-bit select and load-hazard flag; instantiated twice (rs, rt).
//  - Slot registers, stall counter and output registers live in forward_ctrl.
// TESTING
//  - Reset: assert rst mid-stream -> fwd_sel_a/b=00, stall=0, stall_count=0 immediately.
//  - ADD R3 then ADD R4,R3,R1 back-to-back -> second instr in EX sees fwd_sel_a=01, sel_b=00.
//  - ADD R3; NOP; SUB R5,R2,R3 -> SUB in EX sees fwd_sel_b=10, sel_a=00.
//  - LW R2 then ADD R6,R2,R2 -> stall=1 for exactly 1 cycle, then both selects=10, count=1.
//  - Write to R0 then read R0 -> selects stay 00, no stall; ADD R3 twice then read R3 -> 01.
//  - LW R2 + dependent ADD with flush=1 same cycle -> stall=0, selects 00; count 2^CNT_W-1 stays.

Source files
------------

// File: rtl/forward_ctrl_pkg.sv
// Shared definitions for the operand-forwarding controller.
//
// Contents:
//   fwd_sel_e     - 2-bit EX operand mux select codes
//                   (register file, EX/MEM result, MEM/WB result)
//   DEF_REG_W     - default register-index width (8 architectural registers)
//   DEF_CNT_W     - default stall performance counter width
package forward_ctrl_pkg;

  // Mux select codes for the EX-stage 3:1 operand muxes. 2'b11 is unused.
  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_EXMEM   = 2'b01,
    FWD_MEMWB   = 2'b10
  } fwd_sel_e;

  localparam int DEF_REG_W = 3;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/forward_ctrl_compare.sv
// Combinational per-operand forwarding decision (module fwd_compare).
//
// Ports:
//   src         in   REG_W  source register index being read in ID
//   use_src     in   1      ID instruction actually reads src
//   ex_valid    in   1      EX slot holds a real instruction
//   ex_wr_en    in   1      EX slot instruction writes a register
//   ex_rd       in   REG_W  EX slot destination register
//   ex_is_load  in   1      EX slot instruction is a load
//   mem_valid   in   1      MEM slot holds a real instruction
//   mem_wr_en   in   1      MEM slot instruction writes a register
//   mem_rd      in   REG_W  MEM slot destination register
//   sel         out  2      forwarding select for this operand
//   load_hazard out  1      operand depends on a load still in EX
module fwd_compare
  import forward_ctrl_pkg::*;
#(
  parameter int REG_W = DEF_REG_W
) (
  input  logic [REG_W-1:0] src,
  input  logic             use_src,
  input  logic             ex_valid,
  input  logic             ex_wr_en,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             mem_valid,
  input  logic             mem_wr_en,
  input  logic [REG_W-1:0] mem_rd,
  output logic [1:0]       sel,
  output logic             load_hazard
);

  logic src_live;
  logic ex_match;
  logic mem_match;

  // R0 is hardwired to zero, so a read of R0 never needs forwarding.
  assign src_live  = use_src && (src != '0);
  assign ex_match  = src_live && ex_valid  && ex_wr_en  && (ex_rd  == src);
  assign mem_match = src_live && mem_valid && mem_wr_en && (mem_rd == src);

  // The younger producer (EX) holds the newest value, so it wins over MEM.
  always_comb begin
    sel = FWD_REGFILE;
    if (ex_match)
      sel = FWD_EXMEM;
    else if (mem_match)
      sel = FWD_MEMWB;
  end

  // A load in EX has no data yet; the consumer must wait one cycle.
  assign load_hazard = ex_match && ex_is_load;

endmodule

// File: rtl/forward_ctrl.sv
// Operand-forwarding and load-use hazard controller for the 16-bit pipeline.
// Tracks the destination registers of the instructions in EX and MEM, produces
// registered EX operand mux selects, and stalls ID for one cycle on load-use.
//
// Ports:
//   clk          in   1      system clock, rising edge
//   rst          in   1      asynchronous active-high reset
//   id_valid     in   1      ID holds a real instruction
//   id_rs        in   REG_W  source register A
//   id_rt        in   REG_W  source register B
//   id_use_rs    in   1      instruction reads rs
//   id_use_rt    in   1      instruction reads rt
//   id_wr_en     in   1      instruction writes a register
//   id_rd        in   REG_W  destination register
//   id_is_load   in   1      instruction is a memory load
//   flush        in   1      branch taken, kill the ID instruction
//   fwd_sel_a    out  2      registered EX operand A select
//   fwd_sel_b    out  2      registered EX operand B select
//   stall        out  1      combinational hold of PC and IF/ID
//   stall_count  out  CNT_W  saturating count of stall cycles
module forward_ctrl
  import forward_ctrl_pkg::*;
#(
  parameter int REG_W = DEF_REG_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_is_load,
  input  logic             flush,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  // EX slot: instruction issued at the last edge.
  logic             ex_valid;
  logic             ex_wr_en;
  logic [REG_W-1:0] ex_rd;
  logic             ex_is_load;

  // MEM slot: by the time a load reaches MEM its data is forwardable, so the
  // load flag is not needed here.
  logic             mem_valid;
  logic             mem_wr_en;
  logic [REG_W-1:0] mem_rd;

  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       haz_a;
  logic       haz_b;
  logic       issue;

  fwd_compare #(.REG_W(REG_W)) u_cmp_a (
    .src         (id_rs),
    .use_src     (id_use_rs),
    .ex_valid    (ex_valid),
    .ex_wr_en    (ex_wr_en),
    .ex_rd       (ex_rd),
    .ex_is_load  (ex_is_load),
    .mem_valid   (mem_valid),
    .mem_wr_en   (mem_wr_en),
    .mem_rd      (mem_rd),
    .sel         (sel_a),
    .load_hazard (haz_a)
  );

  fwd_compare #(.REG_W(REG_W)) u_cmp_b (
    .src         (id_rt),
    .use_src     (id_use_rt),
    .ex_valid    (ex_valid),
    .ex_wr_en    (ex_wr_en),
    .ex_rd       (ex_rd),
    .ex_is_load  (ex_is_load),
    .mem_valid   (mem_valid),
    .mem_wr_en   (mem_wr_en),
    .mem_rd      (mem_rd),
    .sel         (sel_b),
    .load_hazard (haz_b)
  );

  // Flush outranks stall: a killed instruction never waits on a load.
  assign stall = id_valid && !flush && (haz_a || haz_b);
  assign issue = id_valid && !flush && !stall;

  // Slot shift, output select registers and stall counter. Anything that does
  // not issue (idle, stalled, flushed) enters EX as a bubble with select 00.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_wr_en    <= 1'b0;
      ex_rd       <= '0;
      ex_is_load  <= 1'b0;
      mem_valid   <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_rd      <= '0;
      fwd_sel_a   <= FWD_REGFILE;
      fwd_sel_b   <= FWD_REGFILE;
      stall_count <= '0;
    end else begin
      mem_valid <= ex_valid;
      mem_wr_en <= ex_wr_en;
      mem_rd    <= ex_rd;
      if (issue) begin
        ex_valid   <= 1'b1;
        ex_wr_en   <= id_wr_en;
        ex_rd      <= id_rd;
        ex_is_load <= id_is_load;
        fwd_sel_a  <= sel_a;
        fwd_sel_b  <= sel_b;
      end else begin
        ex_valid   <= 1'b0;
        ex_wr_en   <= 1'b0;
        ex_rd      <= '0;
        ex_is_load <= 1'b0;
        fwd_sel_a  <= FWD_REGFILE;
        fwd_sel_b  <= FWD_REGFILE;
      end
      if (stall && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule
